// File: rtl/common_pht2_table.sv
// -----------------------------------------------------------------------------
// common_pht2_table
//   Table of 2^ENTRIES_LOG2 two-bit saturating branch-direction counters.
//   Registered query port, zero-latency saturating update port and a
//   sequential clear engine that rewrites every entry to weakly-not-taken.
//
//   Optional feature macro: COMMON_PHT2_BYPASS_EN
//     defined   -> a query colliding with an accepted update to the same
//                  index at the same edge returns the post-update value.
//     undefined -> the same query returns the pre-update array value.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   i_qvalid, i_qindex       prediction query
//   o_rvalid, o_rcounter,    query response (one cycle after the query);
//   o_rtaken                 o_rtaken is the counter MSB
//   i_uvalid, i_uindex,      update from branch resolution
//   i_utaken                 (1 = increment, 0 = decrement, saturating)
//   i_clear                  pulse that (re)starts the table clear
//   o_busy                   clear engine active
// -----------------------------------------------------------------------------
module common_pht2_table #(
    parameter int ENTRIES_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_qvalid,
    input  logic [ENTRIES_LOG2-1:0] i_qindex,
    output logic                    o_rvalid,
    output logic [1:0]              o_rcounter,
    output logic                    o_rtaken,
    input  logic                    i_uvalid,
    input  logic [ENTRIES_LOG2-1:0] i_uindex,
    input  logic                    i_utaken,
    input  logic                    i_clear,
    output logic                    o_busy
);

    localparam int                    N        = 1 << ENTRIES_LOG2;
    localparam logic [ENTRIES_LOG2-1:0] PTR_LAST = '1;
    localparam logic [ENTRIES_LOG2-1:0] PTR_ONE  = {{(ENTRIES_LOG2-1){1'b0}}, 1'b1};
    localparam logic [1:0]            WEAK_NT  = 2'b01;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [ENTRIES_LOG2-1:0] ptr_q, ptr_d;
    logic [1:0]              cnt_q [N];
    logic [1:0]              cnt_d [N];
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rcounter_q, rcounter_d;

    logic                    upd_acc;
    logic [1:0]              upd_cur;
    logic [2:0]              inc_sum;
    logic [2:0]              dec_dif;
    logic [1:0]              upd_next;
    logic [1:0]              rd_val;

    // Saturating inc/dec: bit 2 of the 3-bit result is the carry (inc) or
    // borrow (dec); when it is set the counter keeps its old value.
    always_comb begin
        upd_cur  = cnt_q[i_uindex];
        inc_sum  = {1'b0, upd_cur} + 3'd1;
        dec_dif  = {1'b0, upd_cur} - 3'd1;
        if (i_utaken) upd_next = inc_sum[2] ? upd_cur : inc_sum[1:0];
        else          upd_next = dec_dif[2] ? upd_cur : dec_dif[1:0];
    end

    // Clear beats a same-edge update; updates during CLEAR are dropped.
    assign upd_acc = i_uvalid && (state_q == IDLE) && !i_clear;

    always_comb begin
`ifdef COMMON_PHT2_BYPASS_EN
        rd_val = (upd_acc && (i_uindex == i_qindex)) ? upd_next : cnt_q[i_qindex];
`else
        rd_val = cnt_q[i_qindex];
`endif
    end

    // Clear FSM and array next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d[ptr_q] = WEAK_NT;
            ptr_d        = ptr_q + PTR_ONE;
            if (ptr_q == PTR_LAST) state_d = IDLE;
        end else if (upd_acc) begin
            cnt_d[i_uindex] = upd_next;
        end
        // A clear pulse in either state (re)starts the sweep from entry 0.
        if (i_clear) begin
            state_d = CLEAR;
            ptr_d   = '0;
        end
    end

    // Query response; during CLEAR entries are logically weakly-not-taken.
    always_comb begin
        rvalid_d   = i_qvalid;
        rcounter_d = rcounter_q;
        if (i_qvalid) rcounter_d = (state_q == CLEAR) ? WEAK_NT : rd_val;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rvalid_q   <= 1'b0;
            rcounter_q <= 2'b00;
            for (int i = 0; i < N; i++) cnt_q[i] <= WEAK_NT;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rvalid_q   <= rvalid_d;
            rcounter_q <= rcounter_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_rvalid   = rvalid_q;
    assign o_rcounter = rcounter_q;
    assign o_rtaken   = rcounter_q[1];
    assign o_busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_common_pht2_table.sv
// -----------------------------------------------------------------------------
// tb_common_pht2_table
//   Self-checking bench for common_pht2_table (ENTRIES_LOG2 = 6). A
//   table-level model tracks counter values and the remaining clear time;
//   directed scenarios plus a randomized run compare the DUT against it.
// -----------------------------------------------------------------------------
module tb_common_pht2_table;

    localparam int L2 = 6;
    localparam int N  = 1 << L2;
`ifdef COMMON_PHT2_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_qvalid, i_uvalid, i_utaken, i_clear;
    logic [L2-1:0] i_qindex, i_uindex;
    logic          o_rvalid, o_rtaken, o_busy;
    logic [1:0]    o_rcounter;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int       mdl [N];
    int       clr_left;
    bit       exp_rv;
    int       exp_rc;

    common_pht2_table #(.ENTRIES_LOG2(L2)) dut (
        .clk(clk), .resetn(resetn),
        .i_qvalid(i_qvalid), .i_qindex(i_qindex),
        .o_rvalid(o_rvalid), .o_rcounter(o_rcounter), .o_rtaken(o_rtaken),
        .i_uvalid(i_uvalid), .i_uindex(i_uindex), .i_utaken(i_utaken),
        .i_clear(i_clear), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        foreach (mdl[i]) mdl[i] = 1;
        clr_left = 0;
        exp_rv   = 1'b0;
        exp_rc   = 0;
    endtask

    // Advance one clock edge, update the model from the inputs seen at that
    // edge, then settle 1 time unit past the edge for sampling.
    task automatic tick();
        bit busy, acc;
        int nv, q, u;
        @(posedge clk);
        q    = int'(i_qindex);
        u    = int'(i_uindex);
        busy = clr_left > 0;
        acc  = i_uvalid && !busy && !i_clear;
        nv   = i_utaken ? ((mdl[u] == 3) ? 3 : mdl[u] + 1)
                        : ((mdl[u] == 0) ? 0 : mdl[u] - 1);
        if (i_qvalid) begin
            exp_rv = 1'b1;
            if (busy)                        exp_rc = 1;
            else if (BYP && acc && (u == q)) exp_rc = nv;
            else                             exp_rc = mdl[q];
        end else begin
            exp_rv = 1'b0;
        end
        if (acc) mdl[u] = nv;
        if (i_clear) begin
            foreach (mdl[i]) mdl[i] = 1;
            clr_left = N;
        end else if (clr_left > 0) begin
            clr_left--;
        end
        #1;
    endtask

    task automatic idle_inputs();
        i_qvalid = 0; i_qindex = '0; i_uvalid = 0; i_uindex = '0;
        i_utaken = 0; i_clear = 0;
    endtask

    task automatic set_entry_taken2(input int idx);
        idle_inputs();
        i_uvalid = 1; i_uindex = L2'(idx); i_utaken = 1;
        tick(); tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({o_rvalid, o_rcounter, o_rtaken, o_busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%b rc=%b rt=%b busy=%b want all 0",
                     o_rvalid, o_rcounter, o_rtaken, o_busy);
        end
        i_qvalid = 1; i_qindex = 6'd5;
        tick();
        idle_inputs();
        n_checks++;
        if (o_rvalid !== 1'b1 || o_rcounter !== 2'b01 || o_rtaken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_query5: got rv=%b rc=%b rt=%b want 1 01 0",
                     o_rvalid, o_rcounter, o_rtaken);
        end
        tick();
        n_checks++;
        if (o_rvalid !== 1'b0 || o_rcounter !== 2'b01) begin
            n_fail++;
            $display("FAIL rvalid_drop_hold: got rv=%b rc=%b want 0 01", o_rvalid, o_rcounter);
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        i_uvalid = 1; i_uindex = 6'd9; i_utaken = 1;
        repeat (4) tick();
        idle_inputs();
        i_qvalid = 1; i_qindex = 6'd9;
        tick();
        n_checks++;
        if (o_rcounter !== 2'b11 || o_rtaken !== 1'b1 || exp_rc != 3) begin
            n_fail++;
            $display("FAIL sat_high: got rc=%b rt=%b model=%0d want 11", o_rcounter, o_rtaken, exp_rc);
        end
        idle_inputs();
        i_uvalid = 1; i_uindex = 6'd9; i_utaken = 0;
        repeat (5) tick();
        idle_inputs();
        i_qvalid = 1; i_qindex = 6'd9;
        tick();
        idle_inputs();
        n_checks++;
        if (o_rcounter !== 2'b00 || o_rtaken !== 1'b0 || exp_rc != 0) begin
            n_fail++;
            $display("FAIL sat_low: got rc=%b model=%0d want 00", o_rcounter, exp_rc);
        end
    endtask

    task automatic test_collision();
        logic [1:0] want;
        want = BYP ? 2'b10 : 2'b01;
        idle_inputs();
        i_qvalid = 1; i_qindex = 6'd3;
        i_uvalid = 1; i_uindex = 6'd3; i_utaken = 1;
        tick();
        idle_inputs();
        n_checks++;
        if (o_rcounter !== want) begin
            n_fail++;
            $display("FAIL collision_same_edge: got %b want %b", o_rcounter, want);
        end
        i_qvalid = 1; i_qindex = 6'd3;
        tick();
        idle_inputs();
        n_checks++;
        if (o_rcounter !== 2'b10) begin
            n_fail++;
            $display("FAIL collision_followup: got %b want 10", o_rcounter);
        end
        // query and update to different indices are independent
        i_qvalid = 1; i_qindex = 6'd3;
        i_uvalid = 1; i_uindex = 6'd4; i_utaken = 0;
        tick();
        idle_inputs();
        n_checks++;
        if (o_rcounter !== 2'b10) begin
            n_fail++;
            $display("FAIL independent_idx: got %b want 10", o_rcounter);
        end
    endtask

    task automatic test_clear();
        int n;
        set_entry_taken2(0);
        set_entry_taken2(63);
        i_clear = 1;
        i_uvalid = 1; i_uindex = 6'd10; i_utaken = 1;  // clear wins, update dropped
        tick();
        idle_inputs();
        n = 0;
        while (o_busy === 1'b1 && n < 200) begin
            n++;
            if (n == 5) begin i_uvalid = 1; i_uindex = 6'd0; i_utaken = 1; end
            i_qvalid = 1; i_qindex = L2'(n);
            tick();
            i_uvalid = 0;
            if (o_busy === 1'b1) begin
                n_checks++;
                if (o_rcounter !== 2'b01) begin
                    n_fail++;
                    $display("FAIL clear_query n=%0d: got %b want 01", n, o_rcounter);
                end
            end
        end
        idle_inputs();
        n_checks++;
        if (n != N) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d cycles want %0d", n, N);
        end
        // first edge after o_busy falls accepts an update
        foreach (i_qindex[k]) ;
        for (int idx = 0; idx < 4; idx++) begin
            int e;
            e = (idx == 0) ? 0 : (idx == 1) ? 63 : (idx == 2) ? 10 : 0;
            i_qvalid = 1; i_qindex = L2'(e);
            if (idx == 3) begin i_uvalid = 1; i_uindex = 6'd20; i_utaken = 1; end
            tick();
            idle_inputs();
            n_checks++;
            if (o_rcounter !== 2'b01) begin
                n_fail++;
                $display("FAIL post_clear_entry%0d: got %b want 01", e, o_rcounter);
            end
        end
        i_qvalid = 1; i_qindex = 6'd20;
        tick();
        idle_inputs();
        n_checks++;
        if (o_rcounter !== 2'b10) begin
            n_fail++;
            $display("FAIL update_after_clear: got %b want 10", o_rcounter);
        end
    endtask

    task automatic test_clear_restart();
        int n;
        idle_inputs();
        i_clear = 1;
        tick();
        i_clear = 0;
        repeat (10) tick();
        i_clear = 1;
        tick();
        i_clear = 0;
        n = 0;
        while (o_busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        n_checks++;
        if (n != N) begin
            n_fail++;
            $display("FAIL restart_busy_len: got %0d cycles want %0d", n, N);
        end
    endtask

    task automatic test_async_reset();
        set_entry_taken2(40);
        i_clear = 1;
        tick();
        i_clear = 0;
        i_qvalid = 1; i_qindex = 6'd40;
        repeat (20) tick();
        #2 resetn = 0;
        model_reset();
        #1;
        n_checks++;
        if (o_busy !== 1'b0 || o_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b rv=%b want 0 0", o_busy, o_rvalid);
        end
        #1 resetn = 1;
        tick();
        tick();
        idle_inputs();
        n_checks++;
        if (o_rcounter !== 2'b01 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_entry40: got rc=%b busy=%b want 01 0", o_rcounter, o_busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            i_qvalid = 1'($urandom_range(0, 1));
            i_uvalid = 1'($urandom_range(0, 3) != 0);
            i_utaken = 1'($urandom_range(0, 1));
            i_qindex = L2'($urandom_range(0, 7));
            i_uindex = ($urandom_range(0, 1) != 0) ? i_qindex : L2'($urandom_range(0, 7));
            i_clear  = 1'($urandom_range(0, 99) == 0);
            tick();
            n_checks++;
            if (o_rvalid !== exp_rv || o_busy !== (clr_left > 0) ||
                (exp_rv && (o_rcounter !== 2'(exp_rc) || o_rtaken !== 2'(exp_rc) >> 1))) begin
                n_fail++;
                $display("FAIL random c=%0d: got rv=%b rc=%b rt=%b busy=%b want rv=%b rc=%0d busy=%0d",
                         c, o_rvalid, o_rcounter, o_rtaken, o_busy, exp_rv, exp_rc, clr_left > 0);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        model_reset();
        #23 resetn = 1;
        @(negedge clk);
        test_reset();
        test_saturation();
        test_collision();
        test_clear();
        test_clear_restart();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/common_pht2_table.md
# common_pht2_table

Table of 2-bit saturating counters for the branch predictor. Each entry holds a taken/not-taken confidence. The block has a registered prediction-query port, a single-cycle update port with saturating increment/decrement, and a sequential clear engine. It sits between the fetch-stage prediction logic and the branch-resolution writeback, and uses the shared 2-bit increment/decrement arithmetic for counter next-state.

## Interface
- ENTRIES_LOG2, default 6: log2 of entry count (N = 2^ENTRIES_LOG2); legal range 2..10.
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- i_qvalid  input  1  prediction query request.
- i_qindex  input  ENTRIES_LOG2  entry to read.
- o_rvalid  output  1  query response valid, one cycle after i_qvalid.
- o_rcounter  output  2  counter value returned for the query.
- o_rtaken  output  1  prediction, equal to o_rcounter[1].
- i_uvalid  input  1  update request from branch resolution.
- i_uindex  input  ENTRIES_LOG2  entry to update.
- i_utaken  input  1  resolved direction: 1 increments, 0 decrements.
- i_clear  input  1  one-cycle pulse that starts a sequential clear of the whole table.
- o_busy  output  1  clear engine active.

## Operation
- Reset (async assert): every counter = 2'b01 (weakly not-taken), o_rvalid=0, o_rcounter=2'b00, o_rtaken=0, o_busy=0, FSM=IDLE, clear pointer=0.
- Update: when i_uvalid=1 and FSM=IDLE, entry[i_uindex] takes the next value at the edge.
  - taken: 0→1, 1→2, 2→3, 3→3.
  - not-taken: 3→2, 2→1, 1→0, 0→0.
  - Saturation is detected by the carry/borrow out of the 2-bit inc/dec. When the carry is set, the entry holds its old value.
- Query: when i_qvalid=1, the response is registered. o_rvalid=1 in the next cycle with o_rcounter = entry[i_qindex] as sampled at the query edge. If i_qvalid=0, o_rvalid=0 and o_rcounter holds its last value.
- Clear FSM:
  - IDLE: on i_clear=1, go to CLEAR with pointer=0.
  - CLEAR: write entry[pointer]=2'b01 and increment pointer each cycle. After the entry N-1 write, return to IDLE.
  - o_busy=1 exactly while in CLEAR.
- During CLEAR:
  - i_uvalid is ignored; the update is dropped with no retry.
  - Queries are still answered, but o_rcounter is forced to 2'b01.
  - i_clear=1 restarts the pointer at 0.
- Simultaneous i_clear and i_uvalid in IDLE: clear wins and the update is dropped.
- Simultaneous query and update, different indices: independent.

## Timing
- Query latency: 1 cycle (request at edge T, response visible after edge T+1 until the next edge).
- Update latency: 0-cycle write. The value is visible to a query issued at edge T+1.
- Clear duration: exactly N cycles of o_busy=1. o_busy rises the cycle after the i_clear edge. An update at the first edge after o_busy falls is accepted.
- Reset deasserted mid-clear: FSM is in IDLE, all entries are 2'b01, and o_busy=0 immediately.
- No combinational path from any input to any output.

## Configuration
- COMMON_PHT2_BYPASS_EN defined: a query and an accepted update to the same index at the same edge return the post-update counter value.
- COMMON_PHT2_BYPASS_EN undefined: the same case returns the pre-update value, a plain registered read of the array.
- The array contents are identical in both configurations; only o_rcounter/o_rtaken differ in the same-index collision case.

## Test plan
- Reset then query index 5 → o_rvalid=1 next cycle, o_rcounter=2'b01, o_rtaken=0.
- Saturation: four taken updates to index 9, then query → o_rcounter=2'b11. Five not-taken updates, then query → 2'b00. No wrap to 3 or 0.
- Collision: entry 3 = 2'b01; query and taken update to index 3 at the same edge → response 2'b10 with COMMON_PHT2_BYPASS_EN, 2'b01 without. A following query returns 2'b10 in both builds.
- Clear: set entries 0 and 63 to 2'b11, pulse i_clear → o_busy=1 for exactly 64 cycles. A taken update to index 0 mid-clear is dropped. Queries during clear return 2'b01. Afterwards entries 0 and 63 read 2'b01.
- Clear restart: pulse i_clear again at clear cycle 10 → o_busy remains high for 64 cycles from the restart.
- Async reset mid-clear (cycle 20) with entry 40 = 2'b11 → o_busy drops without a clock edge. After release, entry 40 reads 2'b01.
